// File: rtl/picobus32_cmd_master_if.sv
// rtl/picobus32_cmd_master_if.sv - command/response streams and PicoBus32 signals of the command master
interface picobus32_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] PicoAddr;
  logic [31:0] PicoDataIn;
  logic        PicoRd;
  logic        PicoWr;
  logic [31:0] PicoDataOut;
  logic        busy;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, PicoDataOut,
    output cmd_ready, rsp_valid, rsp_data, PicoAddr, PicoDataIn, PicoRd, PicoWr,
           busy, wr_count, rd_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, PicoDataOut,
    input  cmd_ready, rsp_valid, rsp_data, PicoAddr, PicoDataIn, PicoRd, PicoWr,
           busy, wr_count, rd_count
  );
endinterface

// File: rtl/picobus32_cmd_master.sv
// rtl/picobus32_cmd_master.sv - command-driven PicoBus32 master with buffered read responses
module picobus32_cmd_master #(
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input logic                    PicoClk,
  input logic                    PicoRst,
  picobus32_cmd_master_if.master bus
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, CAP} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [31:0]   mem [RSP_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(RSP_DEPTH));
  assign empty = (count == '0);
  assign push  = (state == CAP);
  assign pop   = bus.rsp_ready && !empty;

  // Only accepting in IDLE with a free slot reserves room for the read in flight.
  assign bus.cmd_ready = !PicoRst && (state == IDLE) && !full;
  assign bus.rsp_valid = !empty;
  assign bus.rsp_data  = empty ? 32'd0 : mem[rd_ptr];
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      bus.PicoAddr   <= '0;
      bus.PicoDataIn <= '0;
      bus.PicoRd     <= 1'b0;
      bus.PicoWr     <= 1'b0;
      bus.wr_count   <= '0;
      bus.rd_count   <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      bus.PicoAddr   <= '0;
      bus.PicoDataIn <= '0;
      bus.PicoRd     <= 1'b0;
      bus.PicoWr     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.PicoAddr <= bus.cmd_addr;
            if (bus.cmd_op) begin
              bus.PicoRd <= 1'b1;
              state      <= RD;
            end else begin
              bus.PicoWr     <= 1'b1;
              bus.PicoDataIn <= bus.cmd_data;
              state          <= WR;
            end
          end
        end
        WR: begin
          bus.wr_count <= bus.wr_count + 16'd1;
          state        <= IDLE;
        end
        RD: begin
          wait_cnt <= 4'(RD_LATENCY - 1);
          state    <= (RD_LATENCY == 1) ? CAP : WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= CAP;
        end
        CAP: begin
          bus.rd_count <= bus.rd_count + 16'd1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PicoClk) begin
    if (push && !PicoRst) mem[wr_ptr] <= bus.PicoDataOut;
  end
endmodule

// File: doc/picobus32_cmd_master.md
# picobus32_cmd_master

Command-driven PicoBus32 master that sits directly upstream of PicoBus32 register slaves. It accepts write and read commands on a valid/ready stream and drives the shared PicoBus signals one transaction at a time. It captures read data from the OR-combined PicoDataOut and returns it on a buffered valid/ready response stream. It is the bus-side endpoint of the host command path.

## Interface
- RD_LATENCY, 1 — cycles from the PicoRd cycle to the cycle in which slave data is valid on PicoDataOut; legal range 1..15.
- RSP_DEPTH, 4 — response FIFO entries; power of two, minimum 2.
- PicoClk  in  1  — sole clock; all logic on the rising edge.
- PicoRst  in  1  — reset, synchronous, active-high.
- cmd_valid  in  1  — command present.
- cmd_ready  out  1  — command accepted on the edge where cmd_valid && cmd_ready.
- cmd_op  in  1  — 0 = write, 1 = read.
- cmd_addr  in  32  — bus address.
- cmd_data  in  32  — write data; ignored for reads.
- rsp_valid  out  1  — response FIFO not empty.
- rsp_ready  in  1  — pops the FIFO head when rsp_valid && rsp_ready.
- rsp_data  out  32  — FIFO head (read data).
- PicoAddr  out  32  — bus address to slaves.
- PicoDataIn  out  32  — write data to slaves.
- PicoRd  out  1  — read strobe, single cycle.
- PicoWr  out  1  — write strobe, single cycle.
- PicoDataOut  in  32  — OR of all slave read outputs; slaves drive 0 when not addressed.
- busy  out  1  — FSM not in IDLE.
- wr_count  out  16  — completed writes; wraps 0xFFFF→0.
- rd_count  out  16  — completed reads; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, WR, RD, WAIT, CAP.
- IDLE: cmd_ready = !fifo_full. On accept, latch addr/data and go to WR if op=0, otherwise RD.
- WR (1 cycle): PicoWr=1, PicoAddr=latched addr, PicoDataIn=latched data. Increment wr_count. Next state IDLE.
- RD (1 cycle): PicoRd=1, PicoAddr=latched addr, PicoDataIn=0. Load the wait counter with RD_LATENCY-1. Go to CAP if RD_LATENCY=1, otherwise WAIT.
- WAIT: all bus outputs 0. Decrement the counter; go to CAP when it reaches 0.
- CAP (1 cycle): push PicoDataOut into the FIFO. Increment rd_count. Next state IDLE.
- All bus outputs are registered. PicoAddr, PicoDataIn, PicoRd and PicoWr are 0 outside WR/RD, to keep the shared bus clean.
- cmd_ready is 0 in every state except IDLE, so at most one transaction is in flight.
- FIFO not full in IDLE guarantees space for the read in flight.
- FIFO behaviour:
  - Simultaneous push and pop leaves the count unchanged.
  - A pop while empty is ignored.
  - No push occurs when full; this is prevented by cmd_ready.
  - rsp_data is 0 when empty.
- Writes produce no response.
- Reset, including mid-transaction:
  - Next edge: FSM to IDLE, in-flight command dropped, FIFO flushed.
  - All outputs 0: PicoRd, PicoWr, PicoAddr, PicoDataIn, rsp_valid, rsp_data, busy, wr_count, rd_count.
  - cmd_ready is 0 while PicoRst=1 and 1 in the first cycle after release.

## Timing
- Accept edge at end of cycle T.
- Write:
  - PicoWr high in T+1.
  - cmd_ready high again in T+2.
  - Throughput: one write per 2 cycles.
- Read:
  - PicoRd high in T+1.
  - PicoDataOut sampled at the end of cycle T+1+RD_LATENCY.
  - rsp_valid high in T+2+RD_LATENCY when the FIFO was empty.
  - cmd_ready high again in T+2+RD_LATENCY.
- busy is high from T+1 until the FSM returns to IDLE.
- rsp_valid deasserts the cycle after the last entry is popped.

## Test plan
- Reset and idle:
  - Stimulus: hold PicoRst 3 cycles, then release.
  - Required: all outputs 0 during reset; cmd_ready=1 in the first cycle after release; no bus strobes with cmd_valid=0.
- Single write:
  - Stimulus: op=0, addr=0x8, data=0x00000005.
  - Required: PicoWr=1 for exactly one cycle with PicoAddr=0x8 and PicoDataIn=0x5; wr_count=1; rsp_valid stays 0.
- Read latency:
  - Stimulus: RD_LATENCY=1, bus model returns 0xDEADBEEF for addr 0x4 one cycle after PicoRd; issue op=1, addr=0x4.
  - Required: PicoRd pulse one cycle; rsp_data=0xDEADBEEF with rsp_valid in T+3.
  - Repeat with RD_LATENCY=3: rsp_valid in T+5.
- Backpressure and full FIFO:
  - Stimulus: RSP_DEPTH=4, rsp_ready=0, issue 6 reads of addr 0xC returning 1..6.
  - Required: exactly 4 reads issued and cmd_ready stays 0; after 4 pops, remaining reads complete; popped order is 1..6.
- Simultaneous push and pop:
  - Stimulus: FIFO holding 2 entries, rsp_ready=1 in the CAP cycle.
  - Required: count stays 2; data order preserved.
- Reset mid-read:
  - Stimulus: RD_LATENCY=3, assert PicoRst in the WAIT state.
  - Required: no push; rsp_valid=0; rd_count=0; next command after release executes normally.
